// File: rtl/sng_pair.sv
// Stochastic number generator pair: converts two binary values into LFSR-compared bitstreams.
// Define SNG_SHARED_LFSR_EN to derive Y from the bit-reversed X LFSR instead of a second LFSR.
module sng_pair #(
    parameter int               WIDTH  = 8,
    parameter int               LEN_W  = 16,
    parameter logic [WIDTH-1:0] SEED_X = 'h01
`ifndef SNG_SHARED_LFSR_EN
    ,
    parameter logic [WIDTH-1:0] SEED_Y = 'hA5
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_val,
    input  logic [WIDTH-1:0] y_val,
    input  logic [LEN_W-1:0] len,
    output logic             x_out,
    output logic             y_out,
    output logic             out_valid,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [LEN_W-1:0] cnt_q;
    logic [WIDTH-1:0] lfsr_x;
    logic             fb_x;
    logic [WIDTH-1:0] y_cmp;

    // Maximal-length Fibonacci feedback; only 8 and 16 bit widths have tap sets.
    generate
        if (WIDTH == 16) begin : g_taps_x16
            assign fb_x = lfsr_x[15] ^ lfsr_x[14] ^ lfsr_x[12] ^ lfsr_x[3];
        end else begin : g_taps_x8
            assign fb_x = lfsr_x[7] ^ lfsr_x[5] ^ lfsr_x[4] ^ lfsr_x[3];
        end
    endgenerate

`ifdef SNG_SHARED_LFSR_EN
    // Bit reversal of a maximal LFSR is still a permutation of 1..2^WIDTH-1.
    always_comb begin
        y_cmp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y_cmp[i] = lfsr_x[WIDTH-1-i];
        end
    end
`else
    logic [WIDTH-1:0] lfsr_y;
    logic             fb_y;

    generate
        if (WIDTH == 16) begin : g_taps_y16
            assign fb_y = lfsr_y[15] ^ lfsr_y[14] ^ lfsr_y[12] ^ lfsr_y[3];
        end else begin : g_taps_y8
            assign fb_y = lfsr_y[7] ^ lfsr_y[5] ^ lfsr_y[4] ^ lfsr_y[3];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_y <= SEED_Y;
        end else if (accept) begin
            lfsr_y <= SEED_Y;
        end else if (state_q == RUN) begin
            lfsr_y <= {lfsr_y[WIDTH-2:0], fb_y};
        end
    end

    assign y_cmp = lfsr_y;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter holds the number of stream bits still to emit, including the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_reg   <= '0;
            y_reg   <= '0;
            cnt_q   <= '0;
            lfsr_x  <= SEED_X;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_reg  <= x_val;
                y_reg  <= y_val;
                cnt_q  <= len;
                lfsr_x <= SEED_X;
            end else if (state_q == RUN) begin
                cnt_q  <= cnt_q - LEN_W'(1);
                lfsr_x <= {lfsr_x[WIDTH-2:0], fb_x};
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign x_out     = out_valid & (lfsr_x <= x_reg);
    assign y_out     = out_valid & (y_cmp <= y_reg);

endmodule

// File: doc/sng_pair.md
SNG_PAIR -- requirements
Module: sng_pair

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning comparator and LFSR width; only 8 and 16 are supported.
REQ-002 SHALL have parameter LEN_W, default 16, meaning stream-length counter width.
REQ-003 SHALL have parameter SEED_X, default 'h01, meaning the nonzero X LFSR seed.
REQ-004 SHALL have parameter SEED_Y, default 'hA5, meaning the nonzero Y LFSR seed.
REQ-005 SHALL have port clk, input, 1, clock; all state on posedge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, job request.
REQ-008 SHALL have port in_ready, output, 1, block can accept a job.
REQ-009 SHALL have port x_val, input, WIDTH, X binary value.
REQ-010 SHALL have port y_val, input, WIDTH, Y binary value.
REQ-011 SHALL have port len, input, LEN_W, number of stream bits to emit.
REQ-012 SHALL have port x_out, output, 1, X stochastic bit, driving the adder x input.
REQ-013 SHALL have port y_out, output, 1, Y stochastic bit, driving the adder y input.
REQ-014 SHALL have port out_valid, output, 1, x_out/y_out valid this cycle.
REQ-015 SHALL have port done, output, 1, one-cycle end-of-job pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE.
REQ-017 SHALL accept a job on a cycle with in_valid=1 in IDLE: latch x_val, y_val, len; reload both LFSRs with their seeds.
REQ-018 SHALL go IDLE->RUN on accept when len!=0, and IDLE->DONE on accept when len==0 (no out_valid cycles).
REQ-019 SHALL assert out_valid for exactly len consecutive cycles in RUN, the first being the cycle after accept.
REQ-020 SHALL drive x_out = out_valid & (lfsr_x <= x_reg) and y_out = out_valid & (lfsr_y <= y_reg), unsigned compare.
REQ-021 SHALL advance each LFSR one step per RUN cycle and hold it otherwise.
REQ-022 SHALL use Fibonacci XNOR-free LFSRs: WIDTH 8 taps 8,6,5,4; WIDTH 16 taps 16,15,13,4; period 2^WIDTH-1, state never 0.
REQ-023 SHALL, over any 2^WIDTH-1 consecutive RUN cycles, emit exactly x_reg ones on x_out (y likewise); 0 yields all zeros, 2^WIDTH-1 yields all ones.
REQ-024 SHALL go RUN->DONE after the len-th out_valid cycle, and DONE->IDLE after one cycle with done=1.
REQ-025 SHALL ignore in_valid and input data outside IDLE; latched values SHALL not change mid-job.
REQ-026 SHALL allow back-to-back jobs: in IDLE on the cycle after done, a new job is accepted.
REQ-027 SHALL hold out_valid, x_out, y_out at 0 in IDLE and DONE.

Reset
REQ-028 SHALL on rst=1 at a clock edge, from any state including mid-RUN, enter IDLE and load LFSRs with their seeds.
REQ-029 SHALL hold x_reg, y_reg, and the counter at 0 while rst=1.
REQ-030 SHALL present in_ready=1, out_valid=0, x_out=0, y_out=0, done=0 in the cycle after reset; an aborted job produces no done pulse.

Configuration
REQ-031 SHALL, when macro SNG_SHARED_LFSR_EN is defined, omit the Y LFSR and SEED_Y and compare y_reg against the bit-reversed lfsr_x.
REQ-032 SHALL, when SNG_SHARED_LFSR_EN is undefined, use an independent Y LFSR seeded with SEED_Y; REQ-023 SHALL hold in both builds.

Verification
REQ-033 SHALL be tested with: WIDTH=8, x_val=255, y_val=0, len=255 -> 255 out_valid cycles; x_out all 1s, y_out all 0s; done one cycle after the last valid.
REQ-034 SHALL be tested with: x_val=128, y_val=64, len=255 -> exactly 128 x_out ones and 64 y_out ones; repeat the job -> bit-identical streams (reseed).
REQ-035 SHALL be tested with: len=0 accepted -> next cycle done=1, no out_valid; the cycle after that in_ready=1.
REQ-036 SHALL be tested with: in_valid held high through a len=10 job with changing x_val -> in_ready=0 for the whole job, stream unaffected, next job accepted the cycle after done.
REQ-037 SHALL be tested with: rst pulsed at the 5th RUN cycle of a len=100 job -> following cycle IDLE, in_ready=1, out_valid=0, no done pulse.
REQ-038 SHALL be tested with: both builds (SNG_SHARED_LFSR_EN defined and undefined), x_val=y_val=100, len=255 -> 100 ones on each output.
